// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the FIFO access controller.
// Optional statistics counters are enabled with the FIFO_CTRL_STATS_EN macro.
package fifo_ctrl_pkg;

  // Write sequencer: decide/grant in W_IDLE, strobe the FIFO in W_ISSUE.
  typedef enum logic {
    W_IDLE  = 1'b0,
    W_ISSUE = 1'b1
  } wr_state_t;

  // Read sequencer: pop in R_ISSUE, present the captured word in R_DONE.
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_DONE  = 2'd2
  } rd_state_t;

  // Width of the optional statistics counters.
  localparam int STAT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// above ptr, wrapping modulo N_REQ. The pointer itself lives in the parent.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  // Scan requesters starting at ptr; the first hit wins.
  always_comb begin
    int pos;
    logic found;
    logic [IDX_W-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    sel       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      sel = IDX_W'(pos);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/fifo_access_ctrl.sv
// FIFO access controller: round-robin write arbitration among N_REQ requesters
// and a single reader, each turned into one-cycle FIFO strobes. All outputs are
// registered. Define FIFO_CTRL_STATS_EN to add wr_cnt/rd_cnt/full_stall_cnt.
module fifo_access_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int N_REQ   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_wr,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           ack_wr,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [D_WIDTH-1:0]         rd_data,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  input  logic [D_WIDTH-1:0]         fifo_rd_data,
  output logic                       fifo_wr,
  output logic                       fifo_rd,
  output logic [D_WIDTH-1:0]         fifo_wr_data
`ifdef FIFO_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]          wr_cnt,
  output logic [STAT_W-1:0]          rd_cnt,
  output logic [STAT_W-1:0]          full_stall_cnt
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  wr_state_t          wr_state;
  rd_state_t          rd_state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]   grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [D_WIDTH-1:0] data_arr [N_REQ];
  logic               wr_start;
  logic               rd_start;

  // Unpack the flat requester data bus into one word per requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*D_WIDTH +: D_WIDTH];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req_wr),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign wr_start = (wr_state == W_IDLE) && (|req_wr) && !fifo_full;
  assign rd_start = (rd_state == R_IDLE) && rd_req && !fifo_empty;

  // Write sequencer: register the winner, its data and ack, then drop back to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state     <= W_IDLE;
      fifo_wr      <= 1'b0;
      ack_wr       <= '0;
      fifo_wr_data <= '0;
      rr_ptr       <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_start) begin
            wr_state     <= W_ISSUE;
            fifo_wr      <= 1'b1;
            ack_wr       <= grant;
            fifo_wr_data <= data_arr[grant_idx];
            rr_ptr       <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
          end
        end
        default: begin
          wr_state <= W_IDLE;
          fifo_wr  <= 1'b0;
          ack_wr   <= '0;
        end
      endcase
    end
  end

  // Read sequencer: pop, capture the show-ahead head word, then flag it valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= R_IDLE;
      fifo_rd  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_start) begin
            rd_state <= R_ISSUE;
            fifo_rd  <= 1'b1;
          end
        end
        R_ISSUE: begin
          rd_state <= R_DONE;
          fifo_rd  <= 1'b0;
          rd_valid <= 1'b1;
          rd_data  <= fifo_rd_data;
        end
        R_DONE: begin
          rd_state <= R_IDLE;
          rd_valid <= 1'b0;
        end
        default: begin
          rd_state <= R_IDLE;
          fifo_rd  <= 1'b0;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_CTRL_STATS_EN
  // Statistics: wrapping strobe counters and a saturating full-stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      full_stall_cnt <= '0;
    end else begin
      if (fifo_wr) wr_cnt <= wr_cnt + STAT_W'(1);
      if (fifo_rd) rd_cnt <= rd_cnt + STAT_W'(1);
      if ((wr_state == W_IDLE) && (|req_wr) && fifo_full && (full_stall_cnt != '1))
        full_stall_cnt <= full_stall_cnt + STAT_W'(1);
    end
  end
`endif

endmodule
